inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction queue directly upstream of the top controller. Accepts the instruction stream as
//  WORD_LEN-bit beats and assembles them into INST_LEN-bit instructions, LSB beat first.
//  Buffers them in a circular queue and presents the head as show-ahead `instruct`.
//  Pops one instruction per accepted inst_req.
//  Detects the END instruction and holds it at the head as a program-done marker.
// PARAMETERS
//  INST_LEN     160   instruction width; must be an integer multiple of WORD_LEN
//  WORD_LEN     32    input beat width
//  DEPTH_LOG2   4     queue depth = 2**DEPTH_LOG2 instructions
//  END_TYPE     4'hF  inst_type code (bits [3:0]) marking end of program
// PORTS
//  clk          in   1               single clock, all logic on posedge
//  rst          in   1               synchronous reset, active-high
//  flush        in   1               sync clear of queue, partial beat assembly, prog_done
//  wr_data      in   WORD_LEN        instruction beat; beat 0 carries bits [WORD_LEN-1:0]
//  wr_valid     in   1               beat valid
//  wr_ready     out  1               beat accepted when wr_valid && wr_ready
//  instruct     out  INST_LEN        head-of-queue instruction (combinational read of head slot)
//  inst_empty   out  1               1 when queue holds no poppable instruction
//  inst_req     in   1               pop request; acts only when inst_empty==0
//  prog_done    out  1               head slot is an END instruction
//  inst_level   out  DEPTH_LOG2+1    stored instruction count, END included
// BEHAVIOUR
//  - Reset/flush, edge-effective: rptr=wptr=0, level=0, beat_cnt=0, prog_done=0.
//    Outputs after reset: wr_ready=1, inst_empty=1, inst_level=0, instruct=X-free (mem zero-init).
//  - Flush has priority over any push/pop in the same cycle.
//  - Assembly: beat_cnt counts 0..WPI-1, where WPI=INST_LEN/WORD_LEN.
//    Beats 0..WPI-2 shift into an assembly register. On beat WPI-1: mem[wptr] <= {wr_data, asm}.
//    In the same cycle: wptr++, level++, beat_cnt=0.
//  - wr_ready = (level != 2**DEPTH_LOG2). Deasserts for all beats while full; a partial
//    instruction is never dropped.
//  - Latency: the last beat accepted at edge E gives instruct/inst_empty valid in the cycle
//    after E. A pop at edge E exposes the next head in the cycle after E.
//  - inst_empty = (level==0) || prog_done. prog_done = (level!=0) && (mem[rptr][3:0]==END_TYPE).
//  - Pop: inst_req && !inst_empty advances rptr and decrements level.
//    inst_req while inst_empty is ignored (no underflow), and so is inst_req while END is at the head.
//  - END is never popped. It stays at the head until flush or reset.
//    Instructions written behind END are stored but are unreachable until flush.
//  - Push and pop in the same cycle: level unchanged, both pointers advance.
//    At full, a pop in the same cycle does not re-enable wr_ready combinationally.
//  - Pointers wrap modulo 2**DEPTH_LOG2. Full and empty are distinguished by level, not by pointers.
//  - A consumer that drives inst_req as a one-cycle registered pulse per instruction is the
//    design point; a held inst_req pops one instruction per cycle.
// CONFIGURATION
//  INST_FETCH_STATS_EN defined: adds outputs stat_comp, stat_wload, stat_bload (16 bit each).
//    They count pops of inst_type 0, 1 and 2 respectively, saturate at 16'hFFFF, and clear on
//    rst or flush. Pops of any other type are not counted.
//  Not defined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package/header inst_defs: inst_type codes (COMPUTE=0, LOAD_W=1, LOAD_B=2, END=4'hF),
//  INST_LEN, and the inst_type field position [3:0].
//  Sub-module inst_word_assembler: beat counter, shift register, flush clear.
//  Its output is a one-cycle inst_valid pulse carrying the INST_LEN word. Queue storage is a
//  register array (LUTRAM) in the top module.
// TESTING
//  1 Reset, then 5 beats 0x00000000,0x11111111,0x22222222,0x33333333,0x44444444 ->
//    inst_empty=0 one cycle after beat 5; instruct=0x44444444_33333333_22222222_11111111_00000000.
//  2 Push 16 type-0 instructions, no pops -> level=16, wr_ready=0.
//    Next beat held with wr_valid=1 is not accepted. One pop -> wr_ready=1 the next cycle.
//  3 Push type-1 then type-2; pulse inst_req for one cycle twice ->
//    instruct [3:0] goes 1 -> 2 -> level 0, inst_empty=1. With stats: stat_wload=1, stat_bload=1.
//  4 Push type-0 then END (4'hF); pop once -> prog_done=1, inst_empty=1, level=1.
//    Further inst_req does not change level. Flush -> prog_done=0, level=0.
//  5 Queue at level 3, 2 beats of a partial instruction, then flush in the same cycle as
//    inst_req and wr_valid -> level=0, beat_cnt=0.
//    The next 5 beats form exactly one instruction.
//  6 Wrap: 40 instructions pushed and popped interleaved, push and pop in the same cycle ->
//    popped sequence matches pushed order; level never exceeds 16; no underflow.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: instruction type codes,
// default geometry and the position of the inst_type field.
package inst_fetch_queue_pkg;

    localparam int DEF_INST_LEN   = 160;
    localparam int DEF_WORD_LEN   = 32;
    localparam int DEF_DEPTH_LOG2 = 4;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 3;

    typedef enum logic [3:0] {
        IT_COMPUTE = 4'h0,
        IT_LOAD_W  = 4'h1,
        IT_LOAD_B  = 4'h2,
        IT_END     = 4'hF
    } inst_type_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        if (cnt == 16'hFFFF) begin
            return cnt;
        end else begin
            return cnt + 16'h0001;
        end
    endfunction

endpackage

// File: rtl/inst_word_assembler.sv
// Collects WORD_LEN-bit beats, LSB beat first, into one INST_LEN-bit instruction and
// emits it as a single-cycle inst_valid_o pulse alongside the last accepted beat.
module inst_word_assembler
    import inst_fetch_queue_pkg::*;
#(
    parameter int INST_LEN = DEF_INST_LEN,
    parameter int WORD_LEN = DEF_WORD_LEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [WORD_LEN-1:0] beat_i,
    input  logic                beat_valid_i,
    input  logic                beat_ready_i,
    output logic                inst_valid_o,
    output logic [INST_LEN-1:0] inst_word_o
);

    localparam int WPI   = INST_LEN / WORD_LEN;
    localparam int ASM_W = INST_LEN - WORD_LEN;
    localparam int CNT_W = (WPI > 1) ? $clog2(WPI) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPI - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
    logic [INST_LEN-1:0] cat_s;
    logic accept_s;
    logic last_s;

    // Beat acceptance, shift-in of the assembly register and the completed-word pulse
    always_comb begin
        accept_s     = beat_valid_i && beat_ready_i;
        last_s       = (beat_cnt_q == CNT_LAST);
        cat_s        = {beat_i, asm_q};
        inst_valid_o = accept_s && last_s && !flush_i;
        inst_word_o  = cat_s;
        beat_cnt_d   = beat_cnt_q;
        asm_d        = asm_q;
        if (flush_i) begin
            beat_cnt_d = '0;
            asm_d      = '0;
        end else if (accept_s) begin
            if (last_s) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_ONE;
                asm_d      = cat_s[INST_LEN-1:WORD_LEN];
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Assembly state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_q      <= asm_d;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue with show-ahead head and END-instruction hold.
// Optional pop statistics are built when INST_FETCH_STATS_EN is defined.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          INST_LEN   = DEF_INST_LEN,
    parameter int          WORD_LEN   = DEF_WORD_LEN,
    parameter int          DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter logic [3:0]  END_TYPE   = IT_END
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [WORD_LEN-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [INST_LEN-1:0]   instruct,
    output logic                  inst_empty,
    input  logic                  inst_req,
    output logic                  prog_done,
    output logic [DEPTH_LOG2:0]   inst_level
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [15:0]           stat_comp,
    output logic [15:0]           stat_wload,
    output logic [15:0]           stat_bload
`endif
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [INST_LEN-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;

    logic                  asm_valid_s;
    logic [INST_LEN-1:0]   asm_word_s;
    logic [INST_LEN-1:0]   head_s;
    logic [3:0]            head_type_s;
    logic                  done_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    inst_word_assembler #(
        .INST_LEN (INST_LEN),
        .WORD_LEN (WORD_LEN)
    ) u_asm (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .beat_i       (wr_data),
        .beat_valid_i (wr_valid),
        .beat_ready_i (wr_ready),
        .inst_valid_o (asm_valid_s),
        .inst_word_o  (asm_word_s)
    );

    // Head decode, push/pop qualification and pointer/level next state; flush wins
    always_comb begin
        head_s      = mem_q[rptr_q];
        head_type_s = head_s[TYPE_MSB:TYPE_LSB];
        done_s      = (level_q != '0) && (head_type_s == END_TYPE);
        empty_s     = (level_q == '0) || done_s;
        wr_ready    = (level_q != LVL_FULL);
        push_s      = asm_valid_s && !flush;
        pop_s       = inst_req && !empty_s && !flush;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        level_d     = level_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            rptr_d = pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
            wptr_d = push_s ? (wptr_q + PTR_ONE) : wptr_q;
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
        end
    end

    // Instruction storage; cleared on reset so the head is never X
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wptr_q] <= asm_word_s;
        end
    end

    // Output mapping
    always_comb begin
        instruct   = head_s;
        inst_empty = empty_s;
        prog_done  = done_s;
        inst_level = level_q;
    end

`ifdef INST_FETCH_STATS_EN
    logic [15:0] stat_comp_q, stat_wload_q, stat_bload_q;

    // Saturating per-type pop counters, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stat_comp_q  <= 16'h0000;
            stat_wload_q <= 16'h0000;
            stat_bload_q <= 16'h0000;
        end else if (pop_s) begin
            case (head_type_s)
                IT_COMPUTE: stat_comp_q  <= sat_inc16(stat_comp_q);
                IT_LOAD_W:  stat_wload_q <= sat_inc16(stat_wload_q);
                IT_LOAD_B:  stat_bload_q <= sat_inc16(stat_bload_q);
                default:    stat_comp_q  <= stat_comp_q;
            endcase
        end
    end

    // Statistics outputs
    always_comb begin
        stat_comp  = stat_comp_q;
        stat_wload = stat_wload_q;
        stat_bload = stat_bload_q;
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue-based model.
// Define INST_FETCH_STATS_EN to also check the pop statistics.
module tb_inst_fetch_queue;

    localparam int WPI   = 5;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [31:0]  wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [159:0] instruct;
    logic         inst_empty;
    logic         inst_req;
    logic         prog_done;
    logic [4:0]   inst_level;
`ifdef INST_FETCH_STATS_EN
    logic [15:0]  stat_comp, stat_wload, stat_bload;
`endif

    int checks = 0;
    int errors = 0;

    logic [159:0] mq[$];
    logic [31:0]  mpart [WPI];
    int           mbeats = 0;
    int           m_comp = 0, m_wload = 0, m_bload = 0;
    bit           last_acc = 1'b0;
    int           max_level = 0;

    inst_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .instruct   (instruct),
        .inst_empty (inst_empty),
        .inst_req   (inst_req),
        .prog_done  (prog_done),
        .inst_level (inst_level)
`ifdef INST_FETCH_STATS_EN
        ,
        .stat_comp  (stat_comp),
        .stat_wload (stat_wload),
        .stat_bload (stat_bload)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic bit m_done();
        logic [159:0] h;
        if (mq.size() == 0) return 1'b0;
        h = mq[0];
        return h[3:0] == 4'hF;
    endfunction

    function automatic bit m_empty();
        return (mq.size() == 0) || m_done();
    endfunction

    function automatic logic [159:0] mk(input logic [3:0] t);
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w[3:0] = t;
        return w;
    endfunction

    // One clock: compare DUT against the model on the falling edge, then advance the model.
    task automatic step();
        bit pop;
        bit acc;
        logic [159:0] w;
        logic [159:0] h;
        @(negedge clk);
        if (!rst) begin
            chk("wr_ready", wr_ready, m_ready());
            chk("inst_empty", inst_empty, m_empty());
            chk("prog_done", prog_done, m_done());
            chk("inst_level", inst_level, mq.size());
            if (mq.size() != 0) chk("instruct", instruct, mq[0]);
`ifdef INST_FETCH_STATS_EN
            chk("stat_comp", stat_comp, m_comp);
            chk("stat_wload", stat_wload, m_wload);
            chk("stat_bload", stat_bload, m_bload);
`endif
            if (int'(inst_level) > max_level) max_level = int'(inst_level);
        end
        acc = 1'b0;
        if (rst || flush) begin
            mq.delete();
            mbeats = 0;
            m_comp = 0; m_wload = 0; m_bload = 0;
        end else begin
            pop = inst_req && !m_empty();
            acc = wr_valid && m_ready();
            if (pop) begin
                h = mq.pop_front();
                if (h[3:0] == 4'h0 && m_comp  < 65535) m_comp++;
                if (h[3:0] == 4'h1 && m_wload < 65535) m_wload++;
                if (h[3:0] == 4'h2 && m_bload < 65535) m_bload++;
            end
            if (acc) begin
                mpart[mbeats] = wr_data;
                mbeats++;
                if (mbeats == WPI) begin
                    for (int i = 0; i < WPI; i++) w[i*32 +: 32] = mpart[i];
                    mq.push_back(w);
                    mbeats = 0;
                end
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic push_inst(input logic [159:0] w);
        int guard;
        for (int b = 0; b < WPI; b++) begin
            wr_valid = 1'b1;
            wr_data  = w[b*32 +: 32];
            guard = 0;
            do begin
                step();
                guard++;
            end while (!last_acc && guard < 100);
            if (!last_acc) begin
                checks++;
                errors++;
                $display("FAIL push_timeout actual=%0d required=accepted", guard);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [159:0] w;
        logic [159:0] words [40];
        int idx;
        int beat;
        int cyc;
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; inst_req = 1'b0; wr_data = 32'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_inst_empty", inst_empty, 1'b1);
        chk("rst_inst_level", inst_level, 5'd0);
        chk("rst_instruct", instruct, 160'h0);

        // 1: five beats form one instruction
        push_inst(160'h44444444_33333333_22222222_11111111_00000000);
        chk("t1_instruct", instruct, 160'h44444444_33333333_22222222_11111111_00000000);
        chk("t1_inst_empty", inst_empty, 1'b0);
        do_flush();

        // 2: fill to full, held beat refused, one pop re-opens
        for (int i = 0; i < DEPTH; i++) push_inst(mk(4'h0));
        chk("t2_level_full", inst_level, 5'd16);
        chk("t2_wr_ready_full", wr_ready, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        repeat (3) step();
        chk("t2_held_not_acc", last_acc, 1'b0);
        chk("t2_level_held", inst_level, 5'd16);
        wr_valid = 1'b0;
        inst_req = 1'b1;
        step();
        inst_req = 1'b0;
        chk("t2_ready_after_pop", wr_ready, 1'b1);
        chk("t2_level_after_pop", inst_level, 5'd15);
        do_flush();

        // 3: pop type-1 then type-2
        push_inst(mk(4'h1));
        push_inst(mk(4'h2));
        chk("t3_head_type1", instruct[3:0], 4'h1);
        inst_req = 1'b1; step(); inst_req = 1'b0;
        chk("t3_head_type2", instruct[3:0], 4'h2);
        step();
        inst_req = 1'b1; step(); inst_req = 1'b0;
        chk("t3_level", inst_level, 5'd0);
        chk("t3_inst_empty", inst_empty, 1'b1);
`ifdef INST_FETCH_STATS_EN
        chk("t3_stat_wload", stat_wload, 16'd1);
        chk("t3_stat_bload", stat_bload, 16'd1);
        chk("t3_stat_comp", stat_comp, 16'd0);
`endif
        step();

        // 4: END stays at head until flush
        do_flush();
        push_inst(mk(4'h0));
        push_inst(mk(4'hF));
        inst_req = 1'b1; step(); inst_req = 1'b0;
        chk("t4_prog_done", prog_done, 1'b1);
        chk("t4_inst_empty", inst_empty, 1'b1);
        chk("t4_level", inst_level, 5'd1);
        inst_req = 1'b1;
        repeat (3) step();
        inst_req = 1'b0;
        chk("t4_level_hold", inst_level, 5'd1);
        do_flush();
        chk("t4_flush_done", prog_done, 1'b0);
        chk("t4_flush_level", inst_level, 5'd0);

        // 5: flush mid-assembly with simultaneous req and beat
        for (int i = 0; i < 3; i++) push_inst(mk(4'($urandom_range(0, 14))));
        wr_valid = 1'b1;
        wr_data = 32'hAAAA0001; step();
        wr_data = 32'hAAAA0002; step();
        flush = 1'b1; inst_req = 1'b1; wr_data = 32'hAAAA0003;
        step();
        flush = 1'b0; inst_req = 1'b0; wr_valid = 1'b0;
        chk("t5_level", inst_level, 5'd0);
        chk("t5_inst_empty", inst_empty, 1'b1);
        w = mk(4'h3);
        push_inst(w);
        chk("t5_level_one", inst_level, 5'd1);
        chk("t5_instruct", instruct, w);
        do_flush();

        // 6: random interleaved push/pop with wrap
        for (int i = 0; i < 40; i++) words[i] = mk(4'($urandom_range(0, 14)));
        idx = 0; beat = 0; cyc = 0; max_level = 0;
        while ((idx < 40 || mq.size() != 0) && cyc < 4000) begin
            wr_valid = (idx < 40) && ($urandom_range(0, 3) != 0);
            wr_data  = (idx < 40) ? words[idx][beat*32 +: 32] : 32'h0;
            inst_req = (cyc >= 150) && ($urandom_range(0, 1) == 1);
            step();
            if (last_acc) begin
                if (beat == WPI - 1) begin
                    beat = 0;
                    idx++;
                end else begin
                    beat++;
                end
            end
            cyc++;
        end
        wr_valid = 1'b0;
        inst_req = 1'b0;
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL t6_timeout actual=%0d required=<4000", cyc);
        end
        step();
        chk("t6_max_level", max_level <= 16, 1'b1);
        chk("t6_reached_full", max_level, 16);
        chk("t6_end_level", inst_level, 5'd0);
        chk("t6_end_empty", inst_empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
